// File: rtl/vga_pkg.sv
// Shared encodings, FSM state type and colour-bar constants for the VGA timing generator.
package vga_pkg;

  localparam int unsigned FMT_RGB332 = 0;
  localparam int unsigned FMT_RGB565 = 1;
  localparam int unsigned FMT_RGB888 = 2;

  localparam int unsigned RGB_W    = 24;
  localparam int unsigned COORD_W  = 12;
  localparam int unsigned NUM_BARS = 8;

  localparam logic [COORD_W-1:0] COORD_NONE = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } vga_state_e;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  function automatic int unsigned fmt_width(input int unsigned fmt);
    case (fmt)
      FMT_RGB332: return 8;
      FMT_RGB565: return 16;
      default:    return 24;
    endcase
  endfunction

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pix_expand.sv
// Combinational expansion of an RGB332/RGB565/RGB888 pixel to RGB888, zero-filling the LSBs.
module vga_pix_expand
  import vga_pkg::*;
#(
  parameter  int unsigned PIX_FMT = FMT_RGB332,
  localparam int unsigned PIX_W   = fmt_width(PIX_FMT)
) (
  input  logic [PIX_W-1:0] pix_i,
  output logic [RGB_W-1:0] rgb_c_o
);

  if (PIX_FMT == FMT_RGB332) begin : g_rgb332
    assign rgb_c_o = {pix_i[7:5], 5'b0, pix_i[4:2], 5'b0, pix_i[1:0], 6'b0};
  end else if (PIX_FMT == FMT_RGB565) begin : g_rgb565
    assign rgb_c_o = {pix_i[15:11], 3'b0, pix_i[10:5], 2'b0, pix_i[4:0], 3'b0};
  end else begin : g_rgb888
    assign rgb_c_o = pix_i;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with run/stop FSM, pixel-fetch lead and registered outputs.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN (adds input test_en).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter  int unsigned H_SYNC   = 96,
  parameter  int unsigned H_BACK   = 40,
  parameter  int unsigned H_LEFT   = 8,
  parameter  int unsigned H_VALID  = 640,
  parameter  int unsigned H_RIGHT  = 8,
  parameter  int unsigned H_FRONT  = 8,
  parameter  int unsigned V_SYNC   = 2,
  parameter  int unsigned V_BACK   = 25,
  parameter  int unsigned V_TOP    = 8,
  parameter  int unsigned V_VALID  = 480,
  parameter  int unsigned V_BOTTOM = 8,
  parameter  int unsigned V_FRONT  = 2,
  parameter  bit          H_POL    = 1'b1,
  parameter  bit          V_POL    = 1'b1,
  parameter  int unsigned PIX_FMT  = FMT_RGB332,
  parameter  int unsigned PIX_LAT  = 1,
  localparam int unsigned PIX_W    = fmt_width(PIX_FMT)
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic               en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  input  logic [PIX_W-1:0]   pix_data,
  output logic               pix_req,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               hsync,
  output logic               vsync,
  output logic               rgb_valid,
  output logic [RGB_W-1:0]   rgb,
  output logic               frame_start,
  output logic               line_start,
  output logic               busy
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int unsigned CW      = $clog2(H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL);
  localparam int unsigned HA      = H_SYNC + H_BACK + H_LEFT;
  localparam int unsigned VA      = V_SYNC + V_BACK + V_TOP;
  localparam int unsigned HF      = HA - PIX_LAT;

  vga_state_e    state_q, state_d;
  logic [CW-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic          hsync_q, vsync_q, rgb_valid_q, frame_start_q, line_start_q;
  logic [RGB_W-1:0] rgb_q, rgb_d, pix_rgb, src_rgb;
  logic          running, h_last, v_last, h_act, v_act, fetch_h, active;

  assign running = (state_q != IDLE);
  assign h_last  = (cnt_h_q == CW'(H_TOTAL - 1));
  assign v_last  = (cnt_v_q == CW'(V_TOTAL - 1));
  assign h_act   = (cnt_h_q >= CW'(HA)) && (cnt_h_q < CW'(HA + H_VALID));
  assign v_act   = (cnt_v_q >= CW'(VA)) && (cnt_v_q < CW'(VA + V_VALID));
  assign fetch_h = (cnt_h_q >= CW'(HF)) && (cnt_h_q < CW'(HF + H_VALID));
  assign active  = running && h_act && v_act;

  // Run/stop control and raster counters; STOP only returns to IDLE at the last pixel of a frame.
  always_comb begin
    state_d = state_q;
    cnt_h_d = '0;
    cnt_v_d = '0;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = STOP;
      STOP: begin
        if (en)                  state_d = RUN;
        else if (h_last && v_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (running) begin
      cnt_h_d = h_last ? '0 : cnt_h_q + CW'(1);
      cnt_v_d = cnt_v_q;
      if (h_last) cnt_v_d = v_last ? '0 : cnt_v_q + CW'(1);
    end
  end

  vga_pix_expand #(.PIX_FMT(PIX_FMT)) u_pix_expand (
    .pix_i   (pix_data),
    .rgb_c_o (pix_rgb)
  );

`ifdef VGA_TEST_PATTERN_EN
  // cnt_h - HA equals pix_x delayed by PIX_LAT, so bars line up with rgb_valid.
  logic [CW-1:0] act_x;
  logic [2:0]    bar_idx;
  assign act_x   = cnt_h_q - CW'(HA);
  assign bar_idx = 3'(act_x / CW'(H_VALID / NUM_BARS));
  assign src_rgb = test_en ? bar_color(bar_idx) : pix_rgb;
`else
  assign src_rgb = pix_rgb;
`endif

  assign rgb_d = active ? src_rgb : '0;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      rgb_valid_q   <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      hsync_q       <= (running && (cnt_h_q < CW'(H_SYNC))) ? H_POL : ~H_POL;
      vsync_q       <= (running && (cnt_v_q < CW'(V_SYNC))) ? V_POL : ~V_POL;
      rgb_valid_q   <= active;
      rgb_q         <= rgb_d;
      frame_start_q <= running && (cnt_h_q == '0) && (cnt_v_q == '0);
      line_start_q  <= running && (cnt_h_q == '0);
    end
  end

  assign pix_req     = running && fetch_h && v_act;
  assign pix_x       = pix_req ? COORD_W'(cnt_h_q - CW'(HF)) : COORD_NONE;
  assign pix_y       = pix_req ? COORD_W'(cnt_v_q - CW'(VA)) : COORD_NONE;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_valid   = rgb_valid_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign busy        = running;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 27x13 raster with two parameter sets.
module tb_vga_timing_gen;

  localparam int unsigned HS = 4, HB = 3, HL = 1, HV = 16, HR = 1, HFR = 2;
  localparam int unsigned VS = 2, VB = 2, VT = 1, VV = 6, VBO = 1, VFR = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
  logic test_en = 1'b0;
`endif

  logic [7:0]  pix_data_a;
  logic [15:0] pix_data_b = 16'hF81F;
  logic [7:0]  lat [3];

  logic        pix_req_a, hsync_a, vsync_a, rgb_valid_a, fs_a, ls_a, busy_a;
  logic [11:0] pix_x_a, pix_y_a;
  logic [23:0] rgb_a;
  logic        pix_req_b, hsync_b, vsync_b, rgb_valid_b, fs_b, ls_b, busy_b;
  logic [11:0] pix_x_b, pix_y_b;
  logic [23:0] rgb_b;

  int n_total = 0;
  int n_pass  = 0;
  int kk      = 0;

  always #5 clk = ~clk;

  // Pixel source for dut A: pix_x[7:0] returned PIX_LAT = 3 clocks later.
  always @(posedge clk) begin
    lat[0] <= pix_x_a[7:0];
    lat[1] <= lat[0];
    lat[2] <= lat[1];
  end
  assign pix_data_a = lat[2];

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HFR),
    .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT), .V_VALID(VV), .V_BOTTOM(VBO), .V_FRONT(VFR),
    .H_POL(1'b1), .V_POL(1'b1), .PIX_FMT(0), .PIX_LAT(3)
  ) u_dut_a (
    .vga_clk(clk), .sys_rst(rst), .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .pix_data(pix_data_a), .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .hsync(hsync_a), .vsync(vsync_a), .rgb_valid(rgb_valid_a), .rgb(rgb_a),
    .frame_start(fs_a), .line_start(ls_a), .busy(busy_a)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HFR),
    .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT), .V_VALID(VV), .V_BOTTOM(VBO), .V_FRONT(VFR),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_FMT(1), .PIX_LAT(1)
  ) u_dut_b (
    .vga_clk(clk), .sys_rst(rst), .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .pix_data(pix_data_b), .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .hsync(hsync_b), .vsync(vsync_b), .rgb_valid(rgb_valid_b), .rgb(rgb_b),
    .frame_start(fs_b), .line_start(ls_b), .busy(busy_b)
  );

  typedef struct {
    int          k;
    logic        hs, vs, val;
    logic [23:0] rgb;
    logic        ls, fs, req;
    logic [11:0] px, py;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, kk);
  endtask

  // From a posedge (target == kk) or a negedge (target > kk): advance to the negedge after edge target.
  task automatic step_to(input int target);
    repeat (target - kk) @(posedge clk);
    kk = target;
    @(negedge clk);
  endtask

  vec_t vecs[$];
  int   hs_cnt, vs_cnt, val_cnt, req_cnt, ls_cnt, fs_cnt, busy_low, rgb_b_bad;
  int   fs_first, fs_second;

  initial begin
    // k: edges since the first RUN edge; registered outputs reflect counter k-1, pix_* counter k.
    vecs.push_back('{  0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{  1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{  2, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{  5, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{ 28, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{ 55, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{140, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 12'd0,   12'd0});
    vecs.push_back('{143, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 12'd3,   12'd0});
    vecs.push_back('{144, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 12'd4,   12'd0});
    vecs.push_back('{145, 1'b0, 1'b0, 1'b1, 24'h000040, 1'b0, 1'b0, 1'b1, 12'd5,   12'd0});
    vecs.push_back('{159, 1'b0, 1'b0, 1'b1, 24'h0060C0, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{160, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{290, 1'b0, 1'b0, 1'b1, 24'h0040C0, 1'b0, 1'b0, 1'b1, 12'd15,  12'd5});
    vecs.push_back('{303, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{351, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF});
    vecs.push_back('{352, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 12'hFFF, 12'hFFF});

    // Reset / IDLE values.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",    32'(busy_a),  32'd0);
    check("rst_hsync_a", 32'(hsync_a), 32'd0);
    check("rst_vsync_a", 32'(vsync_a), 32'd0);
    check("rst_hsync_b", 32'(hsync_b), 32'd1);
    check("rst_vsync_b", 32'(vsync_b), 32'd1);
    check("rst_pix_x",   32'(pix_x_a), 32'hFFF);
    check("rst_pix_req", 32'(pix_req_a), 32'd0);
    check("rst_rgb",     32'(rgb_a),   32'd0);

    // Main raster table.
    en = 1'b1;
    @(posedge clk);
    kk = 0;
    foreach (vecs[i]) begin
      step_to(vecs[i].k);
      check($sformatf("hsync_a@%0d", vecs[i].k), 32'(hsync_a), 32'(vecs[i].hs));
      check($sformatf("vsync_a@%0d", vecs[i].k), 32'(vsync_a), 32'(vecs[i].vs));
      check($sformatf("valid_a@%0d", vecs[i].k), 32'(rgb_valid_a), 32'(vecs[i].val));
      check($sformatf("rgb_a@%0d", vecs[i].k), 32'(rgb_a), 32'(vecs[i].rgb));
      check($sformatf("line_a@%0d", vecs[i].k), 32'(ls_a), 32'(vecs[i].ls));
      check($sformatf("frame_a@%0d", vecs[i].k), 32'(fs_a), 32'(vecs[i].fs));
      check($sformatf("req_a@%0d", vecs[i].k), 32'(pix_req_a), 32'(vecs[i].req));
      check($sformatf("pix_x_a@%0d", vecs[i].k), 32'(pix_x_a), 32'(vecs[i].px));
      check($sformatf("pix_y_a@%0d", vecs[i].k), 32'(pix_y_a), 32'(vecs[i].py));
      check($sformatf("busy_a@%0d", vecs[i].k), 32'(busy_a), 32'd1);
      check($sformatf("hsync_b@%0d", vecs[i].k), 32'(hsync_b), 32'(!vecs[i].hs));
      check($sformatf("vsync_b@%0d", vecs[i].k), 32'(vsync_b), 32'(!vecs[i].vs));
      check($sformatf("valid_b@%0d", vecs[i].k), 32'(rgb_valid_b), 32'(vecs[i].val));
      check($sformatf("rgb_b@%0d", vecs[i].k), 32'(rgb_b), vecs[i].val ? 32'h00F800F8 : 32'd0);
    end

    // Drop en in line 3 of the second frame; it must finish that frame, then go IDLE.
    step_to(432);
    en = 1'b0;
    while (busy_a && kk < 1500) step_to(kk + 1);
    check("stop_idle_k", 32'(kk), 32'd702);
    check("stop_busy_b", 32'(busy_b), 32'd0);
    check("stop_rgb",    32'(rgb_a), 32'd0);
    check("stop_valid",  32'(rgb_valid_a), 32'd0);
    check("stop_pix_x",  32'(pix_x_a), 32'hFFF);
    step_to(kk + 1);
    check("idle_hsync_b", 32'(hsync_b), 32'd1);
    check("idle_vsync_b", 32'(vsync_b), 32'd1);
    check("idle_line",    32'(ls_a), 32'd0);
    step_to(kk + 6);
    check("idle_hold_busy", 32'(busy_a), 32'd0);
    check("idle_hold_req",  32'(pix_req_a), 32'd0);

    // Restart; en dropped and reasserted during the frame must not disturb the raster.
    en = 1'b1;
    @(posedge clk);
    kk = 0;
    hs_cnt = 0; vs_cnt = 0; val_cnt = 0; req_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    busy_low = 0; rgb_b_bad = 0; fs_first = -1; fs_second = -1;
    for (int i = 1; i <= 352; i++) begin
      step_to(i);
      if (!busy_a) busy_low++;
      if (fs_a) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (i <= 351) begin
        hs_cnt  += int'(hsync_a);
        vs_cnt  += int'(vsync_a);
        val_cnt += int'(rgb_valid_a);
        req_cnt += int'(pix_req_a);
        ls_cnt  += int'(ls_a);
        fs_cnt  += int'(fs_a);
        if (rgb_b !== (rgb_valid_b ? 24'hF800F8 : 24'h0)) rgb_b_bad++;
      end
      if (i == 100) en = 1'b0;
      if (i == 200) en = 1'b1;
    end
    check("cnt_hsync",   32'(hs_cnt),  32'd52);
    check("cnt_vsync",   32'(vs_cnt),  32'd54);
    check("cnt_valid",   32'(val_cnt), 32'd96);
    check("cnt_req",     32'(req_cnt), 32'd96);
    check("cnt_line",    32'(ls_cnt),  32'd13);
    check("cnt_frame",   32'(fs_cnt),  32'd1);
    check("busy_gap",    32'(busy_low), 32'd0);
    check("rgb_b_frame", 32'(rgb_b_bad), 32'd0);
    check("fs_first",    32'(fs_first), 32'd1);
    check("fs_period",   32'(fs_second - fs_first), 32'd351);

`ifdef VGA_TEST_PATTERN_EN
    test_en = 1'b1;
    step_to(494); check("bar_pre",    32'(rgb_a), 32'h000000);
    step_to(495); check("bar_white0", 32'(rgb_a), 32'hFFFFFF);
    check("bar_white_b", 32'(rgb_b), 32'hFFFFFF);
    step_to(496); check("bar_white1", 32'(rgb_a), 32'hFFFFFF);
    step_to(497); check("bar_yel0",   32'(rgb_a), 32'hFFFF00);
    step_to(498); check("bar_yel1",   32'(rgb_a), 32'hFFFF00);
    step_to(499); check("bar_cyan",   32'(rgb_a), 32'h00FFFF);
    step_to(508); check("bar_blue",   32'(rgb_a), 32'h0000FF);
    check("bar_req", 32'(pix_req_a), 32'd0);
    test_en = 1'b0;
`endif

    // Asynchronous reset in the middle of a line.
    step_to(kk + 40);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",    32'(busy_a),  32'd0);
    check("arst_hsync_a", 32'(hsync_a), 32'd0);
    check("arst_hsync_b", 32'(hsync_b), 32'd1);
    check("arst_valid",   32'(rgb_valid_a), 32'd0);
    check("arst_rgb",     32'(rgb_a),   32'd0);
    check("arst_pix_x",   32'(pix_x_a), 32'hFFF);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
